// File: rtl/mc_wb_ctrl.sv
// mc_wb_ctrl: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RISC-V core,
// with data-memory handshake timeout and retired-instruction counter.
module mc_wb_ctrl #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  opcode,
    input  logic        br_take,
    input  logic        mem_ready,
    output logic        PCWr,
    output logic [1:0]  PCSel,
    output logic        IRWr,
    output logic        RFWr,
    output logic [1:0]  WDSel,
    output logic        DMRd,
    output logic        DMWr,
    output logic        illegal,
    output logic        mem_err,
    output logic [31:0] instret,
    output logic [2:0]  state
);
    typedef enum logic [2:0] {S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_MEM = 3'd3, S_WB = 3'd4} state_t;
    typedef enum logic [3:0] {C_ILL, C_R, C_I, C_LOAD, C_STORE, C_BR, C_JAL, C_JALR, C_LUI, C_AUIPC} cls_t;
    state_t      state_q, state_d;
    cls_t        cls_q, dec_cls;
    logic [7:0]  wcnt_q, wcnt_d;
    logic [31:0] instret_q;
    logic        retire;
    always_comb begin
        case (opcode)
            7'b0110011: dec_cls = C_R;
            7'b0010011: dec_cls = C_I;
            7'b0000011: dec_cls = C_LOAD;
            7'b0100011: dec_cls = C_STORE;
            7'b1100011: dec_cls = C_BR;
            7'b1101111: dec_cls = C_JAL;
            7'b1100111: dec_cls = C_JALR;
            7'b0110111: dec_cls = C_LUI;
            7'b0010111: dec_cls = C_AUIPC;
            default:    dec_cls = C_ILL;
        endcase
    end
    // Classification is used combinationally in DECODE so illegal can pulse there.
    always_comb begin
        PCWr    = 1'b0;
        PCSel   = 2'b00;
        IRWr    = 1'b0;
        RFWr    = 1'b0;
        WDSel   = 2'b00;
        DMRd    = 1'b0;
        DMWr    = 1'b0;
        illegal = 1'b0;
        mem_err = 1'b0;
        retire  = 1'b0;
        state_d = state_q;
        wcnt_d  = wcnt_q;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    IRWr    = 1'b1;
                    state_d = S_DECODE;
                end
                S_DECODE: begin
                    illegal = dec_cls == C_ILL;
                    PCWr    = dec_cls == C_ILL;
                    state_d = dec_cls == C_ILL ? S_FETCH : S_EXEC;
                end
                S_EXEC: begin
                    PCWr    = cls_q == C_BR;
                    PCSel   = cls_q == C_BR ? {1'b0, br_take} : 2'b00;
                    retire  = cls_q == C_BR;
                    wcnt_d  = 8'd0;
                    state_d = cls_q == C_BR ? S_FETCH :
                              (cls_q == C_LOAD || cls_q == C_STORE) ? S_MEM : S_WB;
                end
                S_MEM: begin
                    DMRd = cls_q == C_LOAD;
                    DMWr = cls_q == C_STORE;
                    if (mem_ready) begin
                        PCWr    = cls_q != C_LOAD;
                        retire  = cls_q != C_LOAD;
                        state_d = cls_q == C_LOAD ? S_WB : S_FETCH;
                    end else begin
                        wcnt_d = wcnt_q + 8'd1;
                        if (wcnt_q == 8'(MEM_TIMEOUT - 1)) begin
                            mem_err = 1'b1;
                            PCWr    = 1'b1;
                            state_d = S_FETCH;
                        end
                    end
                end
                S_WB: begin
                    RFWr    = 1'b1;
                    PCWr    = 1'b1;
                    retire  = 1'b1;
                    WDSel   = cls_q == C_LOAD ? 2'b01 :
                              (cls_q == C_JAL || cls_q == C_JALR) ? 2'b10 :
                              cls_q == C_AUIPC ? 2'b11 : 2'b00;
                    PCSel   = cls_q == C_JAL ? 2'b01 : cls_q == C_JALR ? 2'b10 : 2'b00;
                    state_d = S_FETCH;
                end
                default: state_d = S_FETCH;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            cls_q     <= C_ILL;
            wcnt_q    <= 8'd0;
            instret_q <= 32'd0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            if (state_q == S_DECODE)
                cls_q <= dec_cls;
            if (retire)
                instret_q <= instret_q + 32'd1;
        end
    end
    assign instret = instret_q;
    assign state   = state_q;
endmodule

// File: tb/tb_mc_wb_ctrl.sv
// tb_mc_wb_ctrl: per-cycle vector table for mc_wb_ctrl plus a hand-run timeout CPI sequence.
module tb_mc_wb_ctrl;
    localparam logic [6:0] OP_ADD = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
                           OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                           OP_JALR = 7'b1100111, OP_AUIPC = 7'b0010111, OP_X = 7'b1111111;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  opcode = 7'd0;
    logic        br_take = 1'b0;
    logic        mem_ready = 1'b0;
    logic        PCWr, IRWr, RFWr, DMRd, DMWr, illegal, mem_err;
    logic [1:0]  PCSel, WDSel;
    logic [31:0] instret;
    logic [2:0]  state;
    int          n_chk = 0;
    int          n_fail = 0;

    typedef struct {
        logic        r;
        logic [6:0]  op;
        logic        br;
        logic        rdy;
        logic [2:0]  st;
        logic        pcwr;
        logic [1:0]  pcsel;
        logic        irwr;
        logic        rfwr;
        logic [1:0]  wd;
        logic        dmrd;
        logic        dmwr;
        logic        ill;
        logic        merr;
        logic [31:0] ir;
    } vec_t;
    vec_t vecs[$];

    mc_wb_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .br_take(br_take), .mem_ready(mem_ready),
        .PCWr(PCWr), .PCSel(PCSel), .IRWr(IRWr), .RFWr(RFWr), .WDSel(WDSel),
        .DMRd(DMRd), .DMWr(DMWr), .illegal(illegal), .mem_err(mem_err),
        .instret(instret), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic v(input logic r, input logic [6:0] op, input logic br, input logic rdy,
                     input logic [2:0] st, input logic pcwr, input logic [1:0] pcsel,
                     input logic irwr, input logic rfwr, input logic [1:0] wd,
                     input logic dmrd, input logic dmwr, input logic ill, input logic merr,
                     input logic [31:0] ir);
        vecs.push_back('{r, op, br, rdy, st, pcwr, pcsel, irwr, rfwr, wd, dmrd, dmwr, ill, merr, ir});
    endtask

    initial begin
        int n, merrs, dmwrs;
        //  r  op      br rdy st pcwr sel ir rf wd rd wr il me instret
        v(1, OP_X,    1, 1,  0, 0,   0,  0, 0, 0, 0, 0, 0, 0, 0);
        // ADD
        v(0, OP_X,    0, 0,  0, 0,   0,  1, 0, 0, 0, 0, 0, 0, 0);
        v(0, OP_ADD,  0, 0,  1, 0,   0,  0, 0, 0, 0, 0, 0, 0, 0);
        v(0, OP_X,    1, 1,  2, 0,   0,  0, 0, 0, 0, 0, 0, 0, 0);
        v(0, OP_X,    1, 1,  4, 1,   0,  0, 1, 0, 0, 0, 0, 0, 0);
        // LOAD, three wait cycles
        v(0, OP_X,    0, 1,  0, 0,   0,  1, 0, 0, 0, 0, 0, 0, 1);
        v(0, OP_LD,   0, 1,  1, 0,   0,  0, 0, 0, 0, 0, 0, 0, 1);
        v(0, OP_X,    0, 1,  2, 0,   0,  0, 0, 0, 0, 0, 0, 0, 1);
        v(0, OP_X,    0, 0,  3, 0,   0,  0, 0, 0, 1, 0, 0, 0, 1);
        v(0, OP_X,    0, 0,  3, 0,   0,  0, 0, 0, 1, 0, 0, 0, 1);
        v(0, OP_X,    0, 0,  3, 0,   0,  0, 0, 0, 1, 0, 0, 0, 1);
        v(0, OP_X,    0, 1,  3, 0,   0,  0, 0, 0, 1, 0, 0, 0, 1);
        v(0, OP_X,    0, 0,  4, 1,   0,  0, 1, 1, 0, 0, 0, 0, 1);
        // BRANCH taken, then not taken
        v(0, OP_X,    1, 0,  0, 0,   0,  1, 0, 0, 0, 0, 0, 0, 2);
        v(0, OP_BR,   1, 0,  1, 0,   0,  0, 0, 0, 0, 0, 0, 0, 2);
        v(0, OP_X,    1, 0,  2, 1,   1,  0, 0, 0, 0, 0, 0, 0, 2);
        v(0, OP_X,    1, 0,  0, 0,   0,  1, 0, 0, 0, 0, 0, 0, 3);
        v(0, OP_BR,   1, 0,  1, 0,   0,  0, 0, 0, 0, 0, 0, 0, 3);
        v(0, OP_X,    0, 0,  2, 1,   0,  0, 0, 0, 0, 0, 0, 0, 3);
        // JAL, JALR, AUIPC
        v(0, OP_X,    0, 0,  0, 0,   0,  1, 0, 0, 0, 0, 0, 0, 4);
        v(0, OP_JAL,  0, 0,  1, 0,   0,  0, 0, 0, 0, 0, 0, 0, 4);
        v(0, OP_X,    0, 0,  2, 0,   0,  0, 0, 0, 0, 0, 0, 0, 4);
        v(0, OP_X,    0, 0,  4, 1,   1,  0, 1, 2, 0, 0, 0, 0, 4);
        v(0, OP_X,    0, 0,  0, 0,   0,  1, 0, 0, 0, 0, 0, 0, 5);
        v(0, OP_JALR, 0, 0,  1, 0,   0,  0, 0, 0, 0, 0, 0, 0, 5);
        v(0, OP_X,    0, 0,  2, 0,   0,  0, 0, 0, 0, 0, 0, 0, 5);
        v(0, OP_X,    0, 0,  4, 1,   2,  0, 1, 2, 0, 0, 0, 0, 5);
        v(0, OP_X,    0, 0,  0, 0,   0,  1, 0, 0, 0, 0, 0, 0, 6);
        v(0, OP_AUIPC,0, 0,  1, 0,   0,  0, 0, 0, 0, 0, 0, 0, 6);
        v(0, OP_X,    0, 0,  2, 0,   0,  0, 0, 0, 0, 0, 0, 0, 6);
        v(0, OP_X,    0, 0,  4, 1,   0,  0, 1, 3, 0, 0, 0, 0, 6);
        // STORE timeout
        v(0, OP_X,    0, 0,  0, 0,   0,  1, 0, 0, 0, 0, 0, 0, 7);
        v(0, OP_ST,   0, 0,  1, 0,   0,  0, 0, 0, 0, 0, 0, 0, 7);
        v(0, OP_X,    0, 1,  2, 0,   0,  0, 0, 0, 0, 0, 0, 0, 7);
        v(0, OP_X,    0, 0,  3, 0,   0,  0, 0, 0, 0, 1, 0, 0, 7);
        v(0, OP_X,    0, 0,  3, 0,   0,  0, 0, 0, 0, 1, 0, 0, 7);
        v(0, OP_X,    0, 0,  3, 0,   0,  0, 0, 0, 0, 1, 0, 0, 7);
        v(0, OP_X,    0, 0,  3, 1,   0,  0, 0, 0, 0, 1, 0, 1, 7);
        // STORE with ready in the last allowed cycle
        v(0, OP_X,    0, 0,  0, 0,   0,  1, 0, 0, 0, 0, 0, 0, 7);
        v(0, OP_ST,   0, 0,  1, 0,   0,  0, 0, 0, 0, 0, 0, 0, 7);
        v(0, OP_X,    0, 0,  2, 0,   0,  0, 0, 0, 0, 0, 0, 0, 7);
        v(0, OP_X,    0, 0,  3, 0,   0,  0, 0, 0, 0, 1, 0, 0, 7);
        v(0, OP_X,    0, 0,  3, 0,   0,  0, 0, 0, 0, 1, 0, 0, 7);
        v(0, OP_X,    0, 0,  3, 0,   0,  0, 0, 0, 0, 1, 0, 0, 7);
        v(0, OP_X,    0, 1,  3, 1,   0,  0, 0, 0, 0, 1, 0, 0, 7);
        // illegal opcode
        v(0, OP_X,    0, 0,  0, 0,   0,  1, 0, 0, 0, 0, 0, 0, 8);
        v(0, OP_X,    0, 0,  1, 1,   0,  0, 0, 0, 0, 0, 1, 0, 8);
        // reset during LOAD in MEM
        v(0, OP_X,    0, 0,  0, 0,   0,  1, 0, 0, 0, 0, 0, 0, 8);
        v(0, OP_LD,   0, 0,  1, 0,   0,  0, 0, 0, 0, 0, 0, 0, 8);
        v(0, OP_X,    0, 0,  2, 0,   0,  0, 0, 0, 0, 0, 0, 0, 8);
        v(0, OP_X,    0, 0,  3, 0,   0,  0, 0, 0, 1, 0, 0, 0, 8);
        v(1, OP_X,    1, 1,  3, 0,   0,  0, 0, 0, 0, 0, 0, 0, 8);
        // I-type after reset
        v(0, OP_X,    0, 0,  0, 0,   0,  1, 0, 0, 0, 0, 0, 0, 0);
        v(0, OP_I,    0, 0,  1, 0,   0,  0, 0, 0, 0, 0, 0, 0, 0);
        v(0, OP_X,    0, 0,  2, 0,   0,  0, 0, 0, 0, 0, 0, 0, 0);
        v(0, OP_X,    0, 0,  4, 1,   0,  0, 1, 0, 0, 0, 0, 0, 0);

        repeat (2) @(posedge clk);
        foreach (vecs[i]) begin
            @(negedge clk);
            rst = vecs[i].r;
            opcode = vecs[i].op;
            br_take = vecs[i].br;
            mem_ready = vecs[i].rdy;
            #1;
            chk($sformatf("v%0d state", i), 32'(state), 32'(vecs[i].st));
            chk($sformatf("v%0d PCWr", i), 32'(PCWr), 32'(vecs[i].pcwr));
            chk($sformatf("v%0d PCSel", i), 32'(PCSel), 32'(vecs[i].pcsel));
            chk($sformatf("v%0d IRWr", i), 32'(IRWr), 32'(vecs[i].irwr));
            chk($sformatf("v%0d RFWr", i), 32'(RFWr), 32'(vecs[i].rfwr));
            chk($sformatf("v%0d WDSel", i), 32'(WDSel), 32'(vecs[i].wd));
            chk($sformatf("v%0d DMRd", i), 32'(DMRd), 32'(vecs[i].dmrd));
            chk($sformatf("v%0d DMWr", i), 32'(DMWr), 32'(vecs[i].dmwr));
            chk($sformatf("v%0d illegal", i), 32'(illegal), 32'(vecs[i].ill));
            chk($sformatf("v%0d mem_err", i), 32'(mem_err), 32'(vecs[i].merr));
            chk($sformatf("v%0d instret", i), instret, vecs[i].ir);
        end

        // Timeout abort: FETCH to FETCH must take 3+MEM_TIMEOUT = 7 cycles.
        @(negedge clk);
        opcode = OP_ST;
        mem_ready = 1'b0;
        br_take = 1'b0;
        #1;
        chk("to_start_state", 32'(state), 32'd0);
        chk("to_start_instret", instret, 32'd1);
        n = 0;
        merrs = 0;
        dmwrs = 0;
        while (n < 40) begin
            @(negedge clk);
            #1;
            n++;
            merrs += int'(mem_err);
            dmwrs += int'(DMWr);
            if (state == 3'd0) break;
        end
        chk("to_cycles", 32'(n), 32'd7);
        chk("to_mem_err_pulses", 32'(merrs), 32'd1);
        chk("to_dmwr_cycles", 32'(dmwrs), 32'd4);
        chk("to_instret", instret, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
